row_loader: RTL and testbench
=============================

Name: row_loader

Overview:
- Parametrised successor to the fixed 4-row RAM row builder.
- Fetches a programmable number of consecutive (optionally strided) words from a synchronous-read RAM and packs them into a row vector.
- Presents the row vector to downstream datapath logic with a valid/ready handshake.
- Sits between the RAM and the row-consuming compute stage; one instance per RAM read port.

Parameters:
- N_ROWS, 4, maximum rows per load; size of the row vector.
- WIDTH, 32, bits per row word.
- ADDR_W, 4, RAM address width.
- RD_LAT, 1, RAM read latency in cycles (>=1).
- CNT_W, $clog2(N_ROWS+1), width of the row-count input.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  load request; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address; captured with start.
- n_rows  in  CNT_W  rows to load; captured with start.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rd_en  out  1  RAM read enable.
- mem_rdata  in  WIDTH  RAM read data, valid RD_LAT cycles after the mem_rd_en cycle.
- rows_out  out  N_ROWS*WIDTH  packed rows; row i at bits [i*WIDTH +: WIDTH].
- rows_valid  out  1  rows_out holds a complete load.
- rows_ready  in  1  consumer accepts rows_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; all outputs 0; row buffer cleared; in-flight read returns discarded.
  - Applies mid-operation too; a late mem_rdata after reset is ignored.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE, start=1:
  - Capture base_addr; capture n_rows clamped to N_ROWS.
  - Clear the row buffer to 0.
  - Go to ISSUE, or to DRAIN if the clamped count is 0.
- ISSUE:
  - mem_rd_en=1 every cycle; mem_addr = base + k*STRIDE for k=0..cnt-1.
  - Address wraps mod 2^ADDR_W.
  - After the last issue, go to DRAIN.
- Return tracking:
  - RD_LAT-deep valid shift register.
  - Return j is written to row j at the end of the cycle in which it is present.
- DRAIN:
  - mem_rd_en=0.
  - Go to HOLD once returns received == cnt; with cnt=0 this happens the next cycle.
- HOLD:
  - rows_valid=1 and rows_out stable.
  - Unloaded rows (index >= cnt) read 0.
  - On rows_valid&&rows_ready, go to IDLE next cycle; rows_valid drops the same edge.
- rows_out is forced to 0 whenever rows_valid=0.
- Latency: start in cycle 0, reads in cycles 1..cnt, rows_valid first high in cycle cnt+RD_LAT+1.
- start while busy is ignored, including in the handshake cycle; no queuing.
- rows_ready while not in HOLD has no effect.
- Back-to-back loads: earliest new start is the cycle after the handshake.

Optional Feature:
- Macro ROW_LOADER_STRIDE_EN.
- When defined:
  - Adds input port stride [ADDR_W-1:0], captured with start.
  - Address step = stride, mod 2^ADDR_W.
  - stride=0 rereads base_addr cnt times.
- When undefined:
  - No stride port; step fixed at 1.

Test Plan:
- Basic load: RAM[i]=0xA0+i, base=0, n_rows=4, RD_LAT=1, rows_ready=1. Required: reads at addresses 0..3 in cycles 1..4; rows_valid in cycle 6; rows_out = {0xA3,0xA2,0xA1,0xA0}; busy low in cycle 7.
- Partial load with wrap: base=14, n_rows=3, ADDR_W=4. Required: addresses 14,15,0; rows 0..2 = RAM[14],RAM[15],RAM[0]; row 3 = 0.
- Count edge cases:
  - n_rows=0: rows_valid in cycle 2 with all zeros, no mem_rd_en.
  - n_rows=7 with N_ROWS=4: clamped, exactly 4 reads.
- Backpressure and start masking: rows_ready=0 for 5 cycles. Required: rows_valid held and rows_out stable. start pulsed during HOLD and in the handshake cycle: ignored, no new reads.
- Reset mid-load: rst=1 in cycle 2 of an n_rows=4 load with RD_LAT=2. Required: next cycle all outputs 0 and state IDLE; stale returns are not written; a fresh load then completes correctly.
- Stride (ROW_LOADER_STRIDE_EN): base=1, stride=3, n_rows=4. Required: addresses 1,4,7,10 and rows match those RAM words.

Source files
------------

// File: rtl/row_loader.sv
// -----------------------------------------------------------------------------
// row_loader
// Fetches a programmable number of consecutive (optionally strided) words from
// a synchronous-read RAM and packs them into a row vector that is offered to a
// downstream consumer with a valid/ready handshake.
//
// Optional feature macro: ROW_LOADER_STRIDE_EN
//   defined   : adds stride_i; the address step is the stride captured with start
//   undefined : no stride_i port; the address step is fixed at 1
//
// Ports:
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   start_i       load request, only honoured while idle
//   base_addr_i   first RAM address, captured with start_i
//   n_rows_i      rows to load, captured with start_i and clamped to N_ROWS
//   stride_i      address step, captured with start_i (ROW_LOADER_STRIDE_EN only)
//   mem_addr_o    RAM read address
//   mem_rd_en_o   RAM read enable
//   mem_rdata_i   RAM read data, valid RD_LAT cycles after the read-enable cycle
//   rows_out_o    packed rows, row i at [i*WIDTH +: WIDTH]; zero unless valid
//   rows_valid_o  rows_out_o holds a complete load
//   rows_ready_i  consumer accepts rows_out_o
//   busy_o        high whenever the loader is not idle
// -----------------------------------------------------------------------------
module row_loader #(
    parameter int N_ROWS = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = $clog2(N_ROWS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [CNT_W-1:0]        n_rows_i,
`ifdef ROW_LOADER_STRIDE_EN
    input  logic [ADDR_W-1:0]       stride_i,
`endif
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic                    mem_rd_en_o,
    input  logic [WIDTH-1:0]        mem_rdata_i,
    output logic [N_ROWS*WIDTH-1:0] rows_out_o,
    output logic                    rows_valid_o,
    input  logic                    rows_ready_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic                    mem_rd_en_q;
    logic                    rows_valid_q;
    logic [N_ROWS*WIDTH-1:0] rows_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        issued_q;
    logic [CNT_W-1:0]        rcv_cnt_q;
    // Bit k set means a read issued k+1 cycles ago is in flight; the top bit
    // marks mem_rdata_i as carrying a genuine return in this cycle.
    logic [RD_LAT-1:0]       vld_q;
`ifdef ROW_LOADER_STRIDE_EN
    logic [ADDR_W-1:0]       step_q;
`endif

    logic [CNT_W-1:0]        cnt_d;
    logic [CNT_W-1:0]        rcv_cnt_d;
    logic                    issue_last_s;
    logic                    ret_vld_s;
    logic [ADDR_W-1:0]       step_s;

    assign ret_vld_s = vld_q[RD_LAT-1];

`ifdef ROW_LOADER_STRIDE_EN
    assign step_s = step_q;
`else
    assign step_s = ADDR_W'(1);
`endif

    // Count clamp, return counter look-ahead and last-issue detection.
    always_comb begin
        cnt_d        = n_rows_i;
        rcv_cnt_d    = rcv_cnt_q;
        issue_last_s = 1'b0;
        if (n_rows_i > CNT_W'(N_ROWS)) begin
            cnt_d = CNT_W'(N_ROWS);
        end else begin
            cnt_d = n_rows_i;
        end
        // Including the return present this cycle lets DRAIN leave on the
        // same edge that writes the final row.
        if (ret_vld_s) begin
            rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
        end else begin
            rcv_cnt_d = rcv_cnt_q;
        end
        issue_last_s = ((issued_q + CNT_W'(1)) == cnt_q);
    end

    // Load FSM, read-return tracking and row buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            rows_valid_q <= 1'b0;
            rows_q       <= '0;
            cnt_q        <= '0;
            issued_q     <= '0;
            rcv_cnt_q    <= '0;
            vld_q        <= '0;
`ifdef ROW_LOADER_STRIDE_EN
            step_q       <= '0;
`endif
        end else begin
            // In-flight tracking follows the read enable regardless of state.
            for (int k = RD_LAT - 1; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
            end
            vld_q[0] <= mem_rd_en_q;

            // Return j lands in row j; rows beyond the count stay cleared.
            rcv_cnt_q <= rcv_cnt_d;
            for (int i = 0; i < N_ROWS; i++) begin
                if (ret_vld_s && (rcv_cnt_q == CNT_W'(i))) begin
                    rows_q[i*WIDTH +: WIDTH] <= mem_rdata_i;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mem_addr_q <= base_addr_i;
                        cnt_q      <= cnt_d;
                        issued_q   <= '0;
                        rcv_cnt_q  <= '0;
                        rows_q     <= '0;
`ifdef ROW_LOADER_STRIDE_EN
                        step_q     <= stride_i;
`endif
                        if (cnt_d == CNT_W'(0)) begin
                            state_q     <= S_DRAIN;
                            mem_rd_en_q <= 1'b0;
                        end else begin
                            state_q     <= S_ISSUE;
                            mem_rd_en_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_last_s) begin
                        state_q     <= S_DRAIN;
                        mem_rd_en_q <= 1'b0;
                    end else begin
                        // Address arithmetic wraps naturally at ADDR_W bits.
                        mem_addr_q  <= mem_addr_q + step_s;
                        issued_q    <= issued_q + CNT_W'(1);
                        mem_rd_en_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (rcv_cnt_d == cnt_q) begin
                        state_q      <= S_HOLD;
                        rows_valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rows_ready_i) begin
                        state_q      <= S_IDLE;
                        rows_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    mem_rd_en_q  <= 1'b0;
                    rows_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_rd_en_o  = mem_rd_en_q;
    assign rows_valid_o = rows_valid_q;
    // The buffer fills progressively during a load, so it is masked until valid.
    assign rows_out_o   = rows_valid_q ? rows_q : '0;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_row_loader.sv
// -----------------------------------------------------------------------------
// tb_row_loader
// Two row_loader instances (RD_LAT=1 and RD_LAT=2) driven by shared stimulus,
// each with its own RAM read pipeline. Expected read addresses and expected
// row vectors are queued when a load is launched and consumed when the DUTs
// issue reads or complete a handshake.
// -----------------------------------------------------------------------------
module tb_row_loader;
    localparam int AW = 4;
    localparam int W  = 32;
    localparam int NR = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          rows_ready;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] n_rows;
`ifdef ROW_LOADER_STRIDE_EN
    logic [AW-1:0] stride;
`endif

    logic [AW-1:0]   mem_addr   [2];
    logic            mem_rd_en  [2];
    logic [NR*W-1:0] rows_out   [2];
    logic            rows_valid [2];
    logic            busy       [2];
    logic [W-1:0]    rdata0, rdata1;
    logic [W-1:0]    p1_0, p1_1, p2_1;

    logic [W-1:0]    ram [16];

    int checks, errors, cyc, t0, cnt_g;
    int vrise[2], rd_cnt[2], rd_first[2], hs_cnt[2], busy_fall[2];
    logic prev_valid[2], prev_busy[2], prev_ready;
    logic [NR*W-1:0] prev_rows[2];

    logic [AW-1:0]   exp_addr[$];
    logic [NR*W-1:0] exp_rows0[$];
    logic [NR*W-1:0] exp_rows1[$];

    row_loader #(.N_ROWS(NR), .WIDTH(W), .ADDR_W(AW), .RD_LAT(1)) u_dut_lat1 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .base_addr_i(base_addr), .n_rows_i(n_rows),
`ifdef ROW_LOADER_STRIDE_EN
        .stride_i(stride),
`endif
        .mem_addr_o(mem_addr[0]), .mem_rd_en_o(mem_rd_en[0]), .mem_rdata_i(rdata0),
        .rows_out_o(rows_out[0]), .rows_valid_o(rows_valid[0]),
        .rows_ready_i(rows_ready), .busy_o(busy[0])
    );

    row_loader #(.N_ROWS(NR), .WIDTH(W), .ADDR_W(AW), .RD_LAT(2)) u_dut_lat2 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .base_addr_i(base_addr), .n_rows_i(n_rows),
`ifdef ROW_LOADER_STRIDE_EN
        .stride_i(stride),
`endif
        .mem_addr_o(mem_addr[1]), .mem_rd_en_o(mem_rd_en[1]), .mem_rdata_i(rdata1),
        .rows_out_o(rows_out[1]), .rows_valid_o(rows_valid[1]),
        .rows_ready_i(rows_ready), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: garbage when not enabled exposes sampling on the wrong cycle.
    always @(posedge clk) begin
        p1_0 <= mem_rd_en[0] ? ram[mem_addr[0]] : 32'hDEAD_BEEF;
        p1_1 <= mem_rd_en[1] ? ram[mem_addr[1]] : 32'hDEAD_BEEF;
        p2_1 <= p1_1;
    end
    assign rdata0 = p1_0;
    assign rdata1 = p2_1;

    // Scoreboard consumption and per-cycle observations for the current cycle.
    task automatic monitor();
        logic [AW-1:0]   ea;
        logic [NR*W-1:0] er;
        if (mem_rd_en[0] === 1'b1 || mem_rd_en[1] === 1'b1) begin
            if (exp_addr.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected cyc=%0d: got rd_en %b/%b, expected no read", cyc, mem_rd_en[0], mem_rd_en[1]);
            end else begin
                ea = exp_addr.pop_front();
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (mem_rd_en[d] !== 1'b1 || mem_addr[d] !== ea) begin
                        errors++;
                        $display("FAIL rd_addr dut%0d cyc=%0d: got en=%b addr=%0d, expected en=1 addr=%0d", d, cyc, mem_rd_en[d], mem_addr[d], ea);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (rows_valid[d] !== 1'b1) begin
                checks++;
                if (rows_out[d] !== '0) begin
                    errors++;
                    $display("FAIL rows_masked dut%0d cyc=%0d: got %h, expected 0", d, cyc, rows_out[d]);
                end
            end else begin
                if (prev_valid[d] !== 1'b1) vrise[d] = cyc;
                if (prev_valid[d] === 1'b1 && prev_ready === 1'b0) begin
                    checks++;
                    if (rows_out[d] !== prev_rows[d]) begin
                        errors++;
                        $display("FAIL hold_stable dut%0d cyc=%0d: got %h, expected %h", d, cyc, rows_out[d], prev_rows[d]);
                    end
                end
                if (rows_ready === 1'b1) begin
                    hs_cnt[d]++;
                    checks++;
                    if ((d == 0 && exp_rows0.size() == 0) || (d == 1 && exp_rows1.size() == 0)) begin
                        errors++;
                        $display("FAIL rows_unexpected dut%0d cyc=%0d: got handshake, expected none", d, cyc);
                    end else begin
                        er = (d == 0) ? exp_rows0.pop_front() : exp_rows1.pop_front();
                        if (rows_out[d] !== er) begin
                            errors++;
                            $display("FAIL rows_data dut%0d cyc=%0d: got %h, expected %h", d, cyc, rows_out[d], er);
                        end
                    end
                end
            end
            if (mem_rd_en[d] === 1'b1) begin
                if (rd_cnt[d] == 0) rd_first[d] = cyc;
                rd_cnt[d]++;
            end
            if (prev_busy[d] === 1'b1 && busy[d] === 1'b0) busy_fall[d] = cyc;
            prev_valid[d] = rows_valid[d];
            prev_busy[d]  = busy[d];
            prev_rows[d]  = rows_out[d];
        end
        prev_ready = rows_ready;
    endtask

    task automatic tick();
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int exp_vrise(input int d);
        return (cnt_g == 0) ? t0 + 2 : t0 + cnt_g + (d + 1) + 1;
    endfunction

    // Drives a start pulse and queues the expected reads and row vector.
    task automatic launch(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic [AW-1:0] s);
        logic [AW-1:0]   a;
        logic [NR*W-1:0] r;
        cnt_g = (n > 3'd4) ? 4 : int'(n);
        a = b;
        r = '0;
        for (int k = 0; k < cnt_g; k++) begin
            exp_addr.push_back(a);
            r[k*W +: W] = ram[a];
            a = a + s;
        end
        exp_rows0.push_back(r);
        exp_rows1.push_back(r);
        for (int d = 0; d < 2; d++) begin
            vrise[d] = -1; rd_cnt[d] = 0; rd_first[d] = -1; hs_cnt[d] = 0; busy_fall[d] = -1;
        end
        base_addr = b;
        n_rows    = n;
`ifdef ROW_LOADER_STRIDE_EN
        stride    = s;
`endif
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for both loaders to go idle, then end-of-load checks.
    task automatic finish_load(input string name);
        int i;
        i = 0;
        while (!(busy[0] === 1'b0 && busy[1] === 1'b0) && i < 40) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 40) begin
            errors++;
            $display("FAIL %s_timeout: got busy %b/%b after %0d cycles, expected idle", name, busy[0], busy[1], i);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_cnt[d] != cnt_g) begin
                errors++;
                $display("FAIL %s_reads dut%0d: got %0d, expected %0d", name, d, rd_cnt[d], cnt_g);
            end
            checks++;
            if (vrise[d] != exp_vrise(d)) begin
                errors++;
                $display("FAIL %s_valid_cycle dut%0d: got %0d, expected %0d", name, d, vrise[d] - t0, exp_vrise(d) - t0);
            end
            checks++;
            if (hs_cnt[d] != 1) begin
                errors++;
                $display("FAIL %s_handshakes dut%0d: got %0d, expected 1", name, d, hs_cnt[d]);
            end
        end
        checks++;
        if (exp_addr.size() != 0 || exp_rows0.size() != 0 || exp_rows1.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d/%0d/%0d pending, expected 0", name, exp_addr.size(), exp_rows0.size(), exp_rows1.size());
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (mem_rd_en[d] !== 1'b0 || mem_addr[d] !== 4'd0 || rows_valid[d] !== 1'b0 ||
                rows_out[d] !== '0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got en=%b addr=%0d valid=%b busy=%b rows=%h, expected all 0",
                         d, mem_rd_en[d], mem_addr[d], rows_valid[d], busy[d], rows_out[d]);
            end
        end
    endtask

    task automatic test_basic();
        rows_ready = 1'b1;
        launch(4'd0, 3'd4, 4'd1);
        finish_load("basic");
        checks++;
        if (rd_first[0] != t0 + 1) begin
            errors++;
            $display("FAIL basic_first_read: got cycle %0d, expected 1", rd_first[0] - t0);
        end
        checks++;
        if (busy_fall[0] != t0 + 7) begin
            errors++;
            $display("FAIL basic_busy_low: got cycle %0d, expected 7", busy_fall[0] - t0);
        end
    endtask

    task automatic test_wrap();
        rows_ready = 1'b1;
        launch(4'd14, 3'd3, 4'd1);
        finish_load("wrap");
    endtask

    task automatic test_counts();
        rows_ready = 1'b1;
        launch(4'd7, 3'd0, 4'd1);
        finish_load("count_zero");
        launch(4'd5, 3'd7, 4'd1);
        finish_load("count_clamp");
    endtask

    task automatic test_backpressure();
        int i;
        rows_ready = 1'b0;
        launch(4'd2, 3'd4, 4'd1);
        i = 0;
        while (!(rows_valid[0] === 1'b1 && rows_valid[1] === 1'b1) && i < 30) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 30) begin
            errors++;
            $display("FAIL bp_timeout: got valid %b/%b, expected both valid", rows_valid[0], rows_valid[1]);
        end
        for (int k = 0; k < 5; k++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rows_valid[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_held dut%0d step %0d: got valid=%b, expected 1", d, k, rows_valid[d]);
                end
            end
            base_addr = 4'd9;
            start     = 1'b1;
            tick();
        end
        rows_ready = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || rows_valid[d] !== 1'b0 || mem_rd_en[d] !== 1'b0) begin
                errors++;
                $display("FAIL bp_release dut%0d: got busy=%b valid=%b rd_en=%b, expected 0", d, busy[d], rows_valid[d], mem_rd_en[d]);
            end
            checks++;
            if (rd_cnt[d] != 4 || hs_cnt[d] != 1 || vrise[d] != exp_vrise(d)) begin
                errors++;
                $display("FAIL bp_summary dut%0d: got reads=%0d hs=%0d valid_cycle=%0d, expected 4 1 %0d",
                         d, rd_cnt[d], hs_cnt[d], vrise[d] - t0, exp_vrise(d) - t0);
            end
        end
    endtask

    task automatic test_back_to_back();
        rows_ready = 1'b1;
        launch(4'd6, 3'd2, 4'd1);
        finish_load("back_to_back");
    endtask

    task automatic test_reset_mid();
        rows_ready = 1'b1;
        launch(4'd3, 3'd4, 4'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_addr.delete();
        exp_rows0.delete();
        exp_rows1.delete();
        test_reset();
        launch(4'd8, 3'd2, 4'd1);
        finish_load("reset_fresh");
    endtask

`ifdef ROW_LOADER_STRIDE_EN
    task automatic test_stride();
        rows_ready = 1'b1;
        launch(4'd1, 3'd4, 4'd3);
        finish_load("stride3");
        launch(4'd5, 3'd3, 4'd0);
        finish_load("stride0");
    endtask
`endif

    initial begin
        checks = 0; errors = 0; cyc = 0; t0 = 0; cnt_g = 0;
        for (int i = 0; i < 16; i++) ram[i] = 32'hA0 + 32'(i);
        for (int d = 0; d < 2; d++) begin
            prev_valid[d] = 1'b0; prev_busy[d] = 1'b0; prev_rows[d] = '0;
            vrise[d] = -1; rd_cnt[d] = 0; rd_first[d] = -1; hs_cnt[d] = 0; busy_fall[d] = -1;
        end
        prev_ready = 1'b0;
        rst = 1'b1; start = 1'b0; rows_ready = 1'b0; base_addr = 4'd0; n_rows = 3'd0;
`ifdef ROW_LOADER_STRIDE_EN
        stride = 4'd1;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_wrap();
        test_counts();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef ROW_LOADER_STRIDE_EN
        test_stride();
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
